// File: rtl/dram_axi_master.sv
// ----------------------------------------------------------------------------
// dram_axi_master
//
// Converts single-word CPU-side DRAM requests into single-beat AXI4
// transactions towards the MIG AXI slave port. A write request becomes
// AW+W followed by B; a read request becomes AR followed by R. Only one
// transaction is in flight at a time. New requests are ignored while
// dram_busy is high.
//
// Ports:
//   clk_axi, rstn_axi         clock (rising edge) and async active-low reset
//   dram_oe                   request strobe
//   dram_addr                 byte address, bits [1:0] ignored
//   dram_wdata, dram_we       write word and byte enables (we==0 -> read)
//   dram_rdata, dram_valid    read word and its one-cycle valid pulse
//   dram_busy                 high while a transaction is in flight
//   dram_err                  one-cycle pulse on a nonzero bresp/rresp
//   S_AXI_*                   AXI4 master interface (single beat, 32-bit size)
// ----------------------------------------------------------------------------
module dram_axi_master #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk_axi,
    input  logic                    rstn_axi,

    input  logic                    dram_oe,
    input  logic [31:0]             dram_addr,
    input  logic [31:0]             dram_wdata,
    input  logic [3:0]              dram_we,
    output logic [31:0]             dram_rdata,
    output logic                    dram_valid,
    output logic                    dram_busy,
    output logic                    dram_err,

    output logic                    S_AXI_awid,
    output logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
    output logic [7:0]              S_AXI_awlen,
    output logic [2:0]              S_AXI_awsize,
    output logic [1:0]              S_AXI_awburst,
    output logic                    S_AXI_awlock,
    output logic [3:0]              S_AXI_awcache,
    output logic [2:0]              S_AXI_awprot,
    output logic [3:0]              S_AXI_awqos,
    output logic [3:0]              S_AXI_awregion,
    output logic                    S_AXI_awvalid,
    input  logic                    S_AXI_awready,

    output logic [DATA_WIDTH-1:0]   S_AXI_wdata,
    output logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
    output logic                    S_AXI_wlast,
    output logic                    S_AXI_wvalid,
    input  logic                    S_AXI_wready,

    input  logic                    S_AXI_bid,
    input  logic [1:0]              S_AXI_bresp,
    input  logic                    S_AXI_bvalid,
    output logic                    S_AXI_bready,

    output logic                    S_AXI_arid,
    output logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
    output logic [7:0]              S_AXI_arlen,
    output logic [2:0]              S_AXI_arsize,
    output logic [1:0]              S_AXI_arburst,
    output logic                    S_AXI_arlock,
    output logic [3:0]              S_AXI_arcache,
    output logic [2:0]              S_AXI_arprot,
    output logic [3:0]              S_AXI_arqos,
    output logic [3:0]              S_AXI_arregion,
    output logic                    S_AXI_arvalid,
    input  logic                    S_AXI_arready,

    input  logic                    S_AXI_rid,
    input  logic [DATA_WIDTH-1:0]   S_AXI_rdata,
    input  logic [1:0]              S_AXI_rresp,
    input  logic                    S_AXI_rlast,
    input  logic                    S_AXI_rvalid,
    output logic                    S_AXI_rready
);

    localparam int LANES  = DATA_WIDTH / 32;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic [31:0]             rdata_d;
    logic                    valid_d, err_d;
    logic [LANE_W-1:0]       wr_lane, rd_lane;
    logic                    aw_done, w_done;
    logic                    unused_ok;

    // Fixed single-beat INCR attributes: one 32-bit beat per transaction.
    assign S_AXI_awid     = 1'b0;
    assign S_AXI_awlen    = 8'd0;
    assign S_AXI_awsize   = 3'b010;
    assign S_AXI_awburst  = 2'b01;
    assign S_AXI_awlock   = 1'b0;
    assign S_AXI_awcache  = 4'b0011;
    assign S_AXI_awprot   = 3'b000;
    assign S_AXI_awqos    = 4'd0;
    assign S_AXI_awregion = 4'd0;
    assign S_AXI_wlast    = 1'b1;
    assign S_AXI_arid     = 1'b0;
    assign S_AXI_arlen    = 8'd0;
    assign S_AXI_arsize   = 3'b010;
    assign S_AXI_arburst  = 2'b01;
    assign S_AXI_arlock   = 1'b0;
    assign S_AXI_arcache  = 4'b0011;
    assign S_AXI_arprot   = 3'b000;
    assign S_AXI_arqos    = 4'd0;
    assign S_AXI_arregion = 4'd0;

    // The latched address drives both address channels; only one is valid.
    assign S_AXI_awaddr = addr_q;
    assign S_AXI_araddr = addr_q;
    assign S_AXI_wdata  = wdata_q;
    assign S_AXI_wstrb  = wstrb_q;

    // Lane of the 32-bit word inside the wide data bus.
    if (LANES > 1) begin : g_lane
        assign wr_lane = dram_addr[LANE_W+1:2];
        assign rd_lane = addr_q[LANE_W+1:2];
    end else begin : g_no_lane
        assign wr_lane = '0;
        assign rd_lane = '0;
    end

    // A handshake is done if it completed earlier (valid already dropped)
    // or completes on this edge.
    assign aw_done = !S_AXI_awvalid || S_AXI_awready;
    assign w_done  = !S_AXI_wvalid  || S_AXI_wready;

    // Inputs that carry no information for single-ID, single-beat traffic.
    assign unused_ok = &{1'b0, dram_addr[1:0], S_AXI_rlast, S_AXI_bid, S_AXI_rid};

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = S_AXI_awvalid;
        wvalid_d  = S_AXI_wvalid;
        bready_d  = S_AXI_bready;
        arvalid_d = S_AXI_arvalid;
        rready_d  = S_AXI_rready;
        rdata_d   = dram_rdata;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        unique case (state)
            IDLE: begin
                if (dram_oe) begin
                    addr_d  = {dram_addr[ADDR_WIDTH-1:2], 2'b00};
                    wdata_d = {LANES{dram_wdata}};
                    wstrb_d = '0;
                    wstrb_d[3:0] = dram_we;
                    wstrb_d = wstrb_d << {wr_lane, 2'b00};
                    if (dram_we != 4'd0) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR: begin
                if (S_AXI_awvalid && S_AXI_awready) awvalid_d = 1'b0;
                if (S_AXI_wvalid && S_AXI_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (S_AXI_bvalid) begin
                    bready_d = 1'b0;
                    err_d    = (S_AXI_bresp != 2'b00);
                    state_d  = IDLE;
                end
            end
            RD_ADDR: begin
                if (S_AXI_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (S_AXI_rvalid) begin
                    rdata_d  = S_AXI_rdata[{rd_lane, 5'b00000} +: 32];
                    valid_d  = 1'b1;
                    err_d    = (S_AXI_rresp != 2'b00);
                    rready_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_axi or negedge rstn_axi) begin
        if (!rstn_axi) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            S_AXI_awvalid <= 1'b0;
            S_AXI_wvalid  <= 1'b0;
            S_AXI_bready  <= 1'b0;
            S_AXI_arvalid <= 1'b0;
            S_AXI_rready  <= 1'b0;
            dram_rdata    <= '0;
            dram_valid    <= 1'b0;
            dram_err      <= 1'b0;
            dram_busy     <= 1'b0;
        end else begin
            state         <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            S_AXI_awvalid <= awvalid_d;
            S_AXI_wvalid  <= wvalid_d;
            S_AXI_bready  <= bready_d;
            S_AXI_arvalid <= arvalid_d;
            S_AXI_rready  <= rready_d;
            dram_rdata    <= rdata_d;
            dram_valid    <= valid_d;
            dram_err      <= err_d;
            dram_busy     <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_dram_axi_master.sv
// ----------------------------------------------------------------------------
// tb_dram_axi_master
//
// Drives CPU-side requests into dram_axi_master (DATA_WIDTH=128) against a
// behavioural AXI slave with per-channel ready/valid delays and a byte-level
// memory. Expected AXI requests and CPU-side responses are queued when a
// request is issued and compared when the DUT produces them.
// ----------------------------------------------------------------------------
module tb_dram_axi_master;

    localparam int DW = 128;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn = 1'b0;
    logic          dram_oe = 1'b0;
    logic [31:0]   dram_addr = '0;
    logic [31:0]   dram_wdata = '0;
    logic [3:0]    dram_we = '0;
    logic [31:0]   dram_rdata;
    logic          dram_valid, dram_busy, dram_err;

    logic          S_AXI_awid, S_AXI_awlock, S_AXI_awvalid;
    logic [AW-1:0] S_AXI_awaddr;
    logic [7:0]    S_AXI_awlen;
    logic [2:0]    S_AXI_awsize, S_AXI_awprot;
    logic [1:0]    S_AXI_awburst;
    logic [3:0]    S_AXI_awcache, S_AXI_awqos, S_AXI_awregion;
    logic          S_AXI_awready = 1'b0;
    logic [DW-1:0] S_AXI_wdata;
    logic [DW/8-1:0] S_AXI_wstrb;
    logic          S_AXI_wlast, S_AXI_wvalid;
    logic          S_AXI_wready = 1'b0;
    logic          S_AXI_bid = 1'b0;
    logic [1:0]    S_AXI_bresp = 2'b00;
    logic          S_AXI_bvalid = 1'b0;
    logic          S_AXI_bready;
    logic          S_AXI_arid, S_AXI_arlock, S_AXI_arvalid;
    logic [AW-1:0] S_AXI_araddr;
    logic [7:0]    S_AXI_arlen;
    logic [2:0]    S_AXI_arsize, S_AXI_arprot;
    logic [1:0]    S_AXI_arburst;
    logic [3:0]    S_AXI_arcache, S_AXI_arqos, S_AXI_arregion;
    logic          S_AXI_arready = 1'b0;
    logic          S_AXI_rid = 1'b0;
    logic [DW-1:0] S_AXI_rdata = '0;
    logic [1:0]    S_AXI_rresp = 2'b00;
    logic          S_AXI_rlast = 1'b1;
    logic          S_AXI_rvalid = 1'b0;
    logic          S_AXI_rready;

    dram_axi_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_axi(clk), .rstn_axi(rstn),
        .dram_oe(dram_oe), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
        .dram_we(dram_we), .dram_rdata(dram_rdata), .dram_valid(dram_valid),
        .dram_busy(dram_busy), .dram_err(dram_err),
        .S_AXI_awid(S_AXI_awid), .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awlen(S_AXI_awlen),
        .S_AXI_awsize(S_AXI_awsize), .S_AXI_awburst(S_AXI_awburst), .S_AXI_awlock(S_AXI_awlock),
        .S_AXI_awcache(S_AXI_awcache), .S_AXI_awprot(S_AXI_awprot), .S_AXI_awqos(S_AXI_awqos),
        .S_AXI_awregion(S_AXI_awregion), .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
        .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb), .S_AXI_wlast(S_AXI_wlast),
        .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready),
        .S_AXI_bid(S_AXI_bid), .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid),
        .S_AXI_bready(S_AXI_bready),
        .S_AXI_arid(S_AXI_arid), .S_AXI_araddr(S_AXI_araddr), .S_AXI_arlen(S_AXI_arlen),
        .S_AXI_arsize(S_AXI_arsize), .S_AXI_arburst(S_AXI_arburst), .S_AXI_arlock(S_AXI_arlock),
        .S_AXI_arcache(S_AXI_arcache), .S_AXI_arprot(S_AXI_arprot), .S_AXI_arqos(S_AXI_arqos),
        .S_AXI_arregion(S_AXI_arregion), .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
        .S_AXI_rid(S_AXI_rid), .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp),
        .S_AXI_rlast(S_AXI_rlast), .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready)
    );

    // ---------------------------------------------------------------- checking
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- scoreboard
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [15:0] strb;
        logic [31:0] word;
    } axi_exp_t;

    typedef struct {
        bit          valid;
        logic [31:0] data;
        bit          err;
    } rsp_exp_t;

    axi_exp_t    exp_axi[$];
    rsp_exp_t    exp_rsp[$];
    logic [31:0] rmem [logic [29:0]];

    // Content of never-written slave memory, a function of the word address.
    function automatic logic [31:0] def_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // ---------------------------------------------------------------- slave
    int unsigned aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    int          n_aw = 0, n_w = 0, n_ar = 0;
    int          skew_seen = 0, early_viol = 0, long_pulse = 0;

    logic [127:0] smem [logic [27:0]];

    function automatic logic [127:0] get_line(input logic [27:0] key);
        logic [127:0] l;
        if (smem.exists(key)) return smem[key];
        for (int i = 0; i < 4; i++) l[32*i +: 32] = def_word({key, 4'b0000} + 32'(i * 4));
        return l;
    endfunction

    bit           aw_f, w_f, ar_f, b_f, r_f, aw_got, w_got, rd_pend;
    int unsigned  cnt_aw, cnt_w, cnt_ar, cnt_b, cnt_r;
    logic [31:0]  s_awaddr, s_araddr, rd_addr;
    logic [127:0] s_wdata, s_line;
    logic [15:0]  s_wstrb;
    axi_exp_t     s_ea;

    always begin
        @(negedge clk);
        aw_f = S_AXI_awvalid && S_AXI_awready;
        w_f  = S_AXI_wvalid  && S_AXI_wready;
        ar_f = S_AXI_arvalid && S_AXI_arready;
        b_f  = S_AXI_bvalid  && S_AXI_bready;
        r_f  = S_AXI_rvalid  && S_AXI_rready;
        s_awaddr = S_AXI_awaddr;
        s_araddr = S_AXI_araddr;
        s_wdata  = S_AXI_wdata;
        s_wstrb  = S_AXI_wstrb;
        if (rstn && (aw_f || ar_f)) begin
            if (exp_axi.size() == 0) begin
                check("axi_unexpected", 1, 0);
            end else begin
                s_ea = exp_axi.pop_front();
                check("axi_kind", aw_f, s_ea.wr);
                if (aw_f) begin
                    check("awaddr", s_awaddr, s_ea.addr);
                    check("wstrb", s_wstrb, s_ea.strb);
                    check("wdata", s_wdata, {4{s_ea.word}});
                end else begin
                    check("araddr", s_araddr, s_ea.addr);
                end
            end
        end
        @(posedge clk);
        #1;
        if (!rstn) begin
            S_AXI_awready = 0; S_AXI_wready = 0; S_AXI_arready = 0;
            S_AXI_bvalid = 0; S_AXI_rvalid = 0;
            cnt_aw = 0; cnt_w = 0; cnt_ar = 0; cnt_b = 0; cnt_r = 0;
            aw_got = 0; w_got = 0; rd_pend = 0;
        end else begin
            if (aw_f) begin S_AXI_awready = 0; aw_got = 1; n_aw++; end
            if (w_f) begin
                S_AXI_wready = 0; w_got = 1; n_w++;
                s_line = get_line(s_awaddr[31:4]);
                for (int i = 0; i < 16; i++) if (s_wstrb[i]) s_line[8*i +: 8] = s_wdata[8*i +: 8];
                smem[s_awaddr[31:4]] = s_line;
            end
            if (ar_f) begin S_AXI_arready = 0; rd_pend = 1; rd_addr = s_araddr; n_ar++; end
            if (b_f) begin S_AXI_bvalid = 0; aw_got = 0; w_got = 0; end
            if (r_f) S_AXI_rvalid = 0;

            if (S_AXI_awvalid && !S_AXI_awready) begin
                if (cnt_aw >= aw_dly) begin S_AXI_awready = 1; cnt_aw = 0; end else cnt_aw++;
            end
            if (S_AXI_wvalid && !S_AXI_wready) begin
                if (cnt_w >= w_dly) begin S_AXI_wready = 1; cnt_w = 0; end else cnt_w++;
            end
            if (S_AXI_arvalid && !S_AXI_arready) begin
                if (cnt_ar >= ar_dly) begin S_AXI_arready = 1; cnt_ar = 0; end else cnt_ar++;
            end
            if (aw_got && w_got && !S_AXI_bvalid && !b_f) begin
                if (cnt_b >= b_dly) begin
                    S_AXI_bvalid = 1; S_AXI_bresp = bresp_cfg; cnt_b = 0;
                end else cnt_b++;
            end
            if (rd_pend) begin
                if (cnt_r >= r_dly) begin
                    S_AXI_rvalid = 1; S_AXI_rdata = get_line(rd_addr[31:4]);
                    S_AXI_rresp = rresp_cfg; rd_pend = 0; cnt_r = 0;
                end else cnt_r++;
            end
        end
    end

    // ---------------------------------------------------------------- monitor
    rsp_exp_t m_er;
    logic     valid_prev = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            valid_prev = 1'b0;
        end else begin
            if (dram_valid && valid_prev) long_pulse++;
            valid_prev = dram_valid;
            if (S_AXI_awvalid && !S_AXI_wvalid) skew_seen++;
            if (S_AXI_bready && !(aw_got && w_got)) early_viol++;
            if (dram_valid || dram_err) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    m_er = exp_rsp.pop_front();
                    check("rsp_valid", dram_valid, m_er.valid);
                    if (m_er.valid) check("rsp_rdata", dram_rdata, m_er.data);
                    check("rsp_err", dram_err, m_er.err);
                end
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dram_busy && n < 200);
        if (dram_busy) check("busy_timeout", 1, 0);
    endtask

    // Queues expectations, then presents the request for one cycle. Returns
    // #1 after the accepting edge.
    task automatic start_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
        axi_exp_t    ea;
        rsp_exp_t    er;
        logic [31:0] w;
        int          n = 0;
        @(negedge clk);
        while (dram_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (dram_busy) check("idle_timeout", 1, 0);
        w = rmem.exists(a[31:2]) ? rmem[a[31:2]] : def_word({a[31:2], 2'b00});
        ea.wr   = (we != 4'd0);
        ea.addr = {a[31:2], 2'b00};
        ea.strb = 16'(we) << (4 * a[3:2]);
        ea.word = wd;
        exp_axi.push_back(ea);
        if (we != 4'd0) begin
            for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = wd[8*i +: 8];
            rmem[a[31:2]] = w;
            if (bresp_cfg != 2'b00) begin
                er.valid = 0; er.data = '0; er.err = 1;
                exp_rsp.push_back(er);
            end
        end else begin
            er.valid = 1; er.data = w; er.err = (rresp_cfg != 2'b00);
            exp_rsp.push_back(er);
        end
        dram_oe = 1; dram_addr = a; dram_wdata = wd; dram_we = we;
        @(posedge clk);
        #1;
        dram_oe = 0;
    endtask

    initial begin
        int aw0, w0, ar0, n;
        logic [31:0] ra;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awvalid", S_AXI_awvalid, 0);
        check("rst_wvalid", S_AXI_wvalid, 0);
        check("rst_arvalid", S_AXI_arvalid, 0);
        check("rst_bready", S_AXI_bready, 0);
        check("rst_rready", S_AXI_rready, 0);
        check("rst_busy", dram_busy, 0);
        check("rst_valid", dram_valid, 0);
        check("rst_err", dram_err, 0);
        check("rst_rdata", dram_rdata, 0);
        check("rst_awaddr", S_AXI_awaddr, 0);
        check("rst_wstrb", S_AXI_wstrb, 0);
        check("tie_awsize", S_AXI_awsize, 3'b010);
        check("tie_arburst", S_AXI_arburst, 2'b01);
        check("tie_arcache", S_AXI_arcache, 4'b0011);
        check("tie_wlast", S_AXI_wlast, 1);
        rstn = 1;

        // Full-word write to lane 1
        start_req(32'h14, 32'hDEADBEEF, 4'hF);
        check("wr1_awvalid", S_AXI_awvalid, 1);
        check("wr1_wvalid", S_AXI_wvalid, 1);
        check("wr1_busy", dram_busy, 1);
        check("wr1_wstrb", S_AXI_wstrb, 16'h00F0);
        check("wr1_wdata_lane1", S_AXI_wdata[63:32], 32'hDEADBEEF);
        check("wr1_awaddr", S_AXI_awaddr, 32'h14);
        wait_idle();

        // Read it back from lane 1
        start_req(32'h14, 32'h0, 4'h0);
        check("rd1_arvalid", S_AXI_arvalid, 1);
        wait_idle();

        // W accepted well before AW
        aw0 = n_aw; w0 = n_w; skew_seen = 0;
        aw_dly = 3; w_dly = 0;
        start_req(32'h30, 32'h12345678, 4'hF);
        wait_idle();
        check("skew_aw_count", n_aw - aw0, 1);
        check("skew_w_count", n_w - w0, 1);
        check("skew_w_dropped_first", skew_seen > 0, 1);
        aw_dly = 0;

        // Byte write to lane 2 with SLVERR response
        bresp_cfg = 2'b10;
        start_req(32'h0B, 32'h0000AB00, 4'b0010);
        check("bw_awaddr", S_AXI_awaddr, 32'h08);
        check("bw_wstrb", S_AXI_wstrb, 16'h0200);
        wait_idle();
        bresp_cfg = 2'b00;

        // Read the merged word
        start_req(32'h08, 32'h0, 4'h0);
        wait_idle();

        // Requests while busy are ignored
        aw0 = n_aw; ar0 = n_ar;
        ar_dly = 2; r_dly = 3;
        start_req(32'h14, 32'h0, 4'h0);
        repeat (3) begin
            @(negedge clk);
            dram_oe = 1; dram_addr = 32'h40; dram_we = 4'hF; dram_wdata = 32'hBAD0BAD0;
        end
        @(negedge clk);
        dram_oe = 0;
        wait_idle();
        check("busy_ar_count", n_ar - ar0, 1);
        check("busy_aw_count", n_aw - aw0, 0);
        ar_dly = 0; r_dly = 0;

        // Read with error response
        rresp_cfg = 2'b10;
        start_req(32'h30, 32'h0, 4'h0);
        wait_idle();
        rresp_cfg = 2'b00;

        // Reset while waiting for read data
        r_dly = 10;
        start_req(32'h20, 32'h0, 4'h0);
        n = 0;
        while (!S_AXI_rready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_rd_data", S_AXI_rready, 1);
        #2;
        rstn = 0;
        #1;
        check("abort_arvalid", S_AXI_arvalid, 0);
        check("abort_rready", S_AXI_rready, 0);
        check("abort_busy", dram_busy, 0);
        check("abort_valid", dram_valid, 0);
        exp_rsp.delete();
        repeat (2) @(negedge clk);
        rstn = 1;
        r_dly = 1;
        start_req(32'h14, 32'h0, 4'h0);
        wait_idle();

        // Randomised traffic
        for (int t = 0; t < 16; t++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            r_dly  = $urandom_range(0, 3);
            bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            rresp_cfg = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            ra = 32'($urandom_range(0, 63)) << 2;
            ra[1:0] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                start_req(ra, $urandom, 4'($urandom_range(1, 15)));
            else
                start_req(ra, 32'h0, 4'h0);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        check("sb_axi_empty", exp_axi.size(), 0);
        check("sb_rsp_empty", exp_rsp.size(), 0);
        check("valid_single_cycle", long_pulse, 0);
        check("bready_after_both", early_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "time limit");
    end

endmodule
